// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory request/response channel plus the stream
// presented to decode. The sequencer is the master; memory/decode form the slave side.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        i_valid;
   logic [31:0] i_instr;
   logic [31:0] i_pc;
   logic [31:0] i_npc;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata,
      output i_valid,
      output i_instr,
      output i_pc,
      output i_npc
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata,
      input  i_valid,
      input  i_instr,
      input  i_pc,
      input  i_npc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues in-order word fetches, tracks in-flight requests in a
// tag FIFO and drops responses made stale by restarts from decode, execute or memory.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              d_restart,
   input  logic [31:0]       d_restart_pc,
   input  logic              x_restart,
   input  logic [31:0]       x_restart_pc,
   input  logic              m_restart,
   input  logic [31:0]       m_restart_pc,
   fetch_sequencer_if.master bus,
   output logic [31:0]       perf_restarts,
   output logic              err_spurious
);

   localparam int unsigned     PtrW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned     CntW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);

   logic [31:0]     fpc_q, fpc_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]     tag_pc_q    [MAX_OUTSTANDING];
   logic            tag_stale_q [MAX_OUTSTANDING];

   logic            valid_q;
   logic [31:0]     instr_q;
   logic [31:0]     pc_q;
   logic [31:0]     npc_q;
   logic [31:0]     perf_q;
   logic            err_q;

   logic            restart;
   logic [31:0]     restart_pc;
   logic            req;
   logic            accept;
   logic            pop;
   logic            spurious;
   logic            deliver;
   logic [31:0]     head_pc;
   logic            head_stale;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   // Oldest pipeline stage wins the restart target.
   always_comb begin
      restart    = m_restart | x_restart | d_restart;
      restart_pc = d_restart_pc;
      if (m_restart) begin
         restart_pc = m_restart_pc;
      end else if (x_restart) begin
         restart_pc = x_restart_pc;
      end
   end

   assign req        = ~reset & ~restart & (count_q < MaxCnt);
   assign accept     = req & bus.imem_ready;
   assign pop        = bus.imem_rvalid & (count_q != '0);
   assign spurious   = bus.imem_rvalid & (count_q == '0);
   assign head_pc    = tag_pc_q[rd_ptr_q];
   assign head_stale = tag_stale_q[rd_ptr_q];
   // A response landing in a restart cycle belongs to the abandoned path.
   assign deliver    = pop & ~head_stale & ~restart;

   always_comb begin
      fpc_d    = fpc_q;
      count_d  = count_q + CntW'(accept) - CntW'(pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (restart) begin
         fpc_d = restart_pc;
      end else if (accept) begin
         fpc_d = fpc_q + 32'd4;
      end
      if (accept) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fpc_q    <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         pc_q     <= '0;
         npc_q    <= '0;
         perf_q   <= '0;
         err_q    <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_pc_q[PtrW'(i)]    <= '0;
            tag_stale_q[PtrW'(i)] <= 1'b0;
         end
      end else begin
         fpc_q    <= fpc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         valid_q  <= deliver;
         if (deliver) begin
            instr_q <= bus.imem_rdata;
            pc_q    <= head_pc;
            npc_q   <= head_pc + 32'd4;
         end
         if (restart) begin
            perf_q <= perf_q + 32'd1;
         end
         if (spurious) begin
            err_q <= 1'b1;
         end
         // Marking every slot is safe: the popped slot is gone and no push coincides.
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (restart) begin
               tag_stale_q[PtrW'(i)] <= 1'b1;
            end
         end
         if (accept) begin
            tag_pc_q[wr_ptr_q]    <= fpc_q;
            tag_stale_q[wr_ptr_q] <= 1'b0;
         end
      end
   end

   assign bus.imem_req   = req;
   assign bus.imem_addr  = fpc_q;
   assign bus.i_valid    = valid_q;
   assign bus.i_instr    = instr_q;
   assign bus.i_pc       = pc_q;
   assign bus.i_npc      = npc_q;
   assign perf_restarts  = perf_q;
   assign err_spurious   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a latency-configurable memory model tags each fetch
// with a restart epoch; surviving responses are queued as expected decode deliveries.
module tb_fetch_sequencer;
   localparam logic [31:0] ResetPc = 32'hBFC0_0000;
   localparam int          MaxOut  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        d_restart = 1'b0;
   logic        x_restart = 1'b0;
   logic        m_restart = 1'b0;
   logic [31:0] d_restart_pc = '0;
   logic [31:0] x_restart_pc = '0;
   logic [31:0] m_restart_pc = '0;
   logic [31:0] perf_restarts;
   logic        err_spurious;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC       (ResetPc),
      .MAX_OUTSTANDING(MaxOut)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .d_restart    (d_restart),
      .d_restart_pc (d_restart_pc),
      .x_restart    (x_restart),
      .x_restart_pc (x_restart_pc),
      .m_restart    (m_restart),
      .m_restart_pc (m_restart_pc),
      .bus          (bus),
      .perf_restarts(perf_restarts),
      .err_spurious (err_spurious)
   );

   always #5 clock = ~clock;

   typedef struct { int due; logic [31:0] addr; int epoch; } mreq_t;
   typedef struct { int due; logic [31:0] pc; logic [31:0] instr; } exp_t;

   mreq_t       mem_q[$];
   exp_t        exp_q[$];
   mreq_t       cur_rsp;
   bit          cur_rsp_vld = 1'b0;
   bit          inject = 1'b0;
   int          cyc = 0;
   int          lat = 1;
   int          epoch = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_fpc = ResetPc;
   logic [31:0] acc_log[$];
   logic [31:0] act_pc[$];
   logic [31:0] act_npc[$];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle: sample at negedge, memory model and drives at posedge+1.
   task automatic step();
      bit          acc;
      bit          rs;
      bit          rst_now;
      bit          req_exp;
      int          outstanding;
      logic [31:0] sel;
      logic [31:0] addr;
      exp_t        e;
      @(negedge clock);
      rst_now = reset;
      rs      = m_restart | x_restart | d_restart;
      sel     = m_restart ? m_restart_pc : (x_restart ? x_restart_pc : d_restart_pc);
      if (bus.i_valid === 1'b1) begin
         act_pc.push_back(bus.i_pc);
         act_npc.push_back(bus.i_npc);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (bus.i_valid !== 1'b1 || bus.i_pc !== e.pc || bus.i_instr !== e.instr ||
             bus.i_npc !== e.pc + 32'd4) begin
            failures++;
            $display("FAIL deliver cyc=%0d got v=%b pc=%h instr=%h npc=%h want pc=%h instr=%h npc=%h",
                     cyc, bus.i_valid, bus.i_pc, bus.i_instr, bus.i_npc, e.pc, e.instr,
                     e.pc + 32'd4);
         end
      end else begin
         checks++;
         if (bus.i_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid cyc=%0d got %b want 0 (pc=%h)", cyc, bus.i_valid, bus.i_pc);
         end
      end
      outstanding = mem_q.size() + (cur_rsp_vld ? 1 : 0);
      req_exp     = !rst_now && !rs && (outstanding < MaxOut);
      checks++;
      if (bus.imem_req !== req_exp) begin
         failures++;
         $display("FAIL imem_req cyc=%0d got %b want %b", cyc, bus.imem_req, req_exp);
      end
      acc  = (bus.imem_req === 1'b1) && (bus.imem_ready === 1'b1);
      addr = bus.imem_addr;
      if (acc) begin
         checks++;
         if (addr !== exp_fpc) begin
            failures++;
            $display("FAIL req_addr cyc=%0d got %h want %h", cyc, addr, exp_fpc);
         end
         acc_log.push_back(addr);
      end
      @(posedge clock);
      #1;
      cyc++;
      if (rst_now) begin
         mem_q.delete();
         exp_q.delete();
         epoch++;
         exp_fpc = ResetPc;
      end else begin
         if (cur_rsp_vld && cur_rsp.epoch == epoch && !rs) begin
            exp_q.push_back('{due: cyc, pc: cur_rsp.addr, instr: instr_of(cur_rsp.addr)});
         end
         if (rs) begin
            epoch++;
            exp_fpc = sel;
         end else if (acc) begin
            exp_fpc = exp_fpc + 32'd4;
         end
         if (acc) begin
            mem_q.push_back('{due: cyc - 1 + lat, addr: addr, epoch: epoch});
         end
      end
      cur_rsp_vld = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         cur_rsp          = mem_q.pop_front();
         cur_rsp_vld      = 1'b1;
         bus.imem_rvalid  = 1'b1;
         bus.imem_rdata   = instr_of(cur_rsp.addr);
      end else if (inject) begin
         bus.imem_rvalid  = 1'b1;
         bus.imem_rdata   = 32'hDEAD_BEEF;
      end else begin
         bus.imem_rvalid  = 1'b0;
         bus.imem_rdata   = $urandom();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      acc_log.delete();
      act_pc.delete();
      act_npc.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.imem_ready = 1'b1;
      repeat (3) step();
      checks++;
      if ({bus.i_valid, bus.i_instr, bus.i_pc, bus.i_npc} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b instr=%h pc=%h npc=%h want all 0",
                  bus.i_valid, bus.i_instr, bus.i_pc, bus.i_npc);
      end
      checks++;
      if (perf_restarts !== 32'd0 || err_spurious !== 1'b0) begin
         failures++;
         $display("FAIL reset_counters got perf=%0d err=%b want 0 0", perf_restarts, err_spurious);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== ResetPc) begin
         failures++;
         $display("FAIL reset_first_req got req=%b addr=%h want 1 %h", bus.imem_req,
                  bus.imem_addr, ResetPc);
      end
   endtask

   task automatic test_stream();
      lat = 1;
      acc_log.delete();
      act_pc.delete();
      act_npc.delete();
      for (int i = 0; i < 10; i++) begin
         step();
         if (i >= 1) begin
            checks++;
            if (bus.i_valid !== 1'b1) begin
               failures++;
               $display("FAIL stream_valid step=%0d got %b want 1", i, bus.i_valid);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (acc_log.size() <= k || acc_log[k] !== ResetPc + 32'(4 * k) ||
             act_pc.size() <= k || act_pc[k] !== ResetPc + 32'(4 * k) ||
             act_npc[k] !== ResetPc + 32'(4 * k + 4)) begin
            failures++;
            $display("FAIL stream_seq k=%0d got req=%h pc=%h npc=%h want %h %h %h", k,
                     acc_log[k], act_pc[k], act_npc[k], ResetPc + 32'(4 * k),
                     ResetPc + 32'(4 * k), ResetPc + 32'(4 * k + 4));
         end
      end
   endtask

   task automatic test_restart_flush();
      do_reset();
      lat = 4;
      step();
      step();
      x_restart    = 1'b1;
      x_restart_pc = 32'h8000_1000;
      step();
      x_restart = 1'b0;
      checks++;
      if (bus.imem_addr !== 32'h8000_1000 || perf_restarts !== 32'd1) begin
         failures++;
         $display("FAIL flush_target got addr=%h perf=%0d want 80001000 1", bus.imem_addr,
                  perf_restarts);
      end
      repeat (8) step();
      checks++;
      if (acc_log.size() < 3 || acc_log[2] !== 32'h8000_1000) begin
         failures++;
         $display("FAIL flush_next_req got %h want 80001000", acc_log[2]);
      end
      checks++;
      if (act_pc.size() == 0 || act_pc[0] !== 32'h8000_1000) begin
         failures++;
         $display("FAIL flush_first_delivery got n=%0d pc=%h want 80001000", act_pc.size(),
                  act_pc[0]);
      end
   endtask

   task automatic test_priority();
      do_reset();
      lat = 1;
      d_restart = 1'b1; d_restart_pc = 32'h0000_0100;
      x_restart = 1'b1; x_restart_pc = 32'h0000_0200;
      m_restart = 1'b1; m_restart_pc = 32'h0000_0300;
      step();
      d_restart = 1'b0; x_restart = 1'b0; m_restart = 1'b0;
      checks++;
      if (perf_restarts !== 32'd1) begin
         failures++;
         $display("FAIL prio_perf got %0d want 1", perf_restarts);
      end
      repeat (4) step();
      checks++;
      if (acc_log.size() == 0 || acc_log[0] !== 32'h0000_0300) begin
         failures++;
         $display("FAIL prio_target got %h want 00000300", acc_log[0]);
      end
   endtask

   task automatic test_back_pressure();
      do_reset();
      lat = 4;
      bus.imem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (bus.imem_addr !== ResetPc || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold step=%0d got addr=%h req=%b want %h 1", i, bus.imem_addr,
                     bus.imem_req, ResetPc);
         end
      end
      checks++;
      if (acc_log.size() != 0) begin
         failures++;
         $display("FAIL bp_no_accept got %0d accepts want 0", acc_log.size());
      end
      bus.imem_ready = 1'b1;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL full_req_low step=%0d got %b want 0", i, bus.imem_req);
         end
         if (i == 2) begin
            checks++;
            if (bus.imem_rvalid !== 1'b1) begin
               failures++;
               $display("FAIL full_first_rsp got rvalid=%b want 1", bus.imem_rvalid);
            end
         end
         step();
      end
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== ResetPc + 32'd8) begin
         failures++;
         $display("FAIL full_req_rise got req=%b addr=%h want 1 %h", bus.imem_req,
                  bus.imem_addr, ResetPc + 32'd8);
      end
      repeat (8) step();
      lat = 1;
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 1;
      d_restart    = 1'b1;
      d_restart_pc = 32'hFFFF_FFFC;
      step();
      d_restart = 1'b0;
      repeat (6) step();
      checks++;
      if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
         failures++;
         $display("FAIL wrap_req got %h %h want fffffffc 00000000", acc_log[0], acc_log[1]);
      end
      checks++;
      if (act_npc.size() < 2 || act_npc[0] !== 32'h0 || act_npc[1] !== 32'h4 ||
          act_pc[1] !== 32'h0) begin
         failures++;
         $display("FAIL wrap_npc got npc %h %h pc1 %h want 00000000 00000004 00000000",
                  act_npc[0], act_npc[1], act_pc[1]);
      end
   endtask

   task automatic test_spurious_reset();
      do_reset();
      bus.imem_ready = 1'b0;
      inject = 1'b1;
      step();
      inject = 1'b0;
      step();
      checks++;
      if (err_spurious !== 1'b1 || bus.i_valid !== 1'b0) begin
         failures++;
         $display("FAIL spurious got err=%b valid=%b want 1 0", err_spurious, bus.i_valid);
      end
      bus.imem_ready = 1'b1;
      lat = 1;
      repeat (3) step();
      x_restart    = 1'b1;
      x_restart_pc = 32'h0000_1000;
      step();
      x_restart = 1'b0;
      repeat (4) step();
      checks++;
      if (perf_restarts !== 32'd1 || bus.i_valid !== 1'b1) begin
         failures++;
         $display("FAIL midstream got perf=%0d valid=%b want 1 1", perf_restarts, bus.i_valid);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({bus.i_valid, bus.i_instr, bus.i_pc, bus.i_npc} !== '0 || perf_restarts !== 32'd0 ||
          err_spurious !== 1'b0 || bus.imem_req !== 1'b0) begin
         failures++;
         $display("FAIL midreset got v=%b instr=%h pc=%h npc=%h perf=%0d err=%b req=%b want 0s",
                  bus.i_valid, bus.i_instr, bus.i_pc, bus.i_npc, perf_restarts, err_spurious,
                  bus.imem_req);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.imem_addr !== ResetPc) begin
         failures++;
         $display("FAIL midreset_addr got %h want %h", bus.imem_addr, ResetPc);
      end
      repeat (4) step();
   endtask

   initial begin
      bus.imem_ready  = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      @(posedge clock);
      #1;
      test_reset();
      test_stream();
      test_restart_flush();
      test_priority();
      test_back_pressure();
      test_wrap();
      test_spurious_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
